qos_wrr_scheduler: RTL and testbench

Egress scheduler for the QoS path. It drains the four per-class output FIFOs (P0..P3) into a single 12-bit egress stream using weighted round-robin. It honours downstream almost_full backpressure. Its RESET/INIT/IDLE/ACTIVE state machine mirrors the flow-control FSM convention: weights are latched during INIT, and status is exported as active_out and idle_out.

---
 rtl/qos_wrr_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_qos_wrr_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin egress scheduler draining four class FIFOs into one stream.
// Optional per-class grant counters are enabled by defining QOS_GRANT_CNT_EN.
module qos_wrr_scheduler #(
    parameter int DATA_W         = 12,
    parameter int WEIGHT_W       = 4,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [WEIGHT_W-1:0] weight0,
    input  logic [WEIGHT_W-1:0] weight1,
    input  logic [WEIGHT_W-1:0] weight2,
    input  logic [WEIGHT_W-1:0] weight3,
    input  logic [3:0]          fifo_empty,
    input  logic [DATA_W-1:0]   fifo_data0,
    input  logic [DATA_W-1:0]   fifo_data1,
    input  logic [DATA_W-1:0]   fifo_data2,
    input  logic [DATA_W-1:0]   fifo_data3,
    input  logic                dest_almost_full,
    output logic [3:0]          pop,
    output logic [DATA_W-1:0]   data_out,
    output logic                valid_out,
    output logic [1:0]          grant_idx,
    output logic                active_out,
    output logic                idle_out,
    input  logic                req,
    input  logic [2:0]          idx,
    output logic                cnt_valid,
    output logic [7:0]          cnt_data
);

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

    state_t              state;
    logic [WEIGHT_W-1:0] weight [4];
    logic [WEIGHT_W-1:0] credit [4];
    logic [WEIGHT_W-1:0] weight_in [4];
    logic [DATA_W-1:0]   fifo_data [4];
    logic [1:0]          ptr;
    logic                inflight;
    logic [1:0]          inflight_idx;

    logic                sched_en;
    logic                found;
    logic [1:0]          sel;
    logic [1:0]          cand;
    logic                grant;
    logic                reload;

    assign weight_in[0] = weight0;
    assign weight_in[1] = weight1;
    assign weight_in[2] = weight2;
    assign weight_in[3] = weight3;
    assign fifo_data[0] = fifo_data0;
    assign fifo_data[1] = fifo_data1;
    assign fifo_data[2] = fifo_data2;
    assign fifo_data[3] = fifo_data3;

    assign sched_en = (state == ST_ACTIVE) && !init && !dest_almost_full;

    // Circular search from ptr for the first non-empty class that still has credit.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && !fifo_empty[cand] && (credit[cand] != '0)) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign grant  = sched_en && found;
    assign reload = sched_en && !found && (fifo_empty != 4'hF);
    assign pop    = grant ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RESET;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            ptr        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                weight[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
                credit[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else begin
            case (state)
                ST_RESET: begin
                    if (init) begin
                        state <= ST_INIT;
                    end else begin
                        state    <= ST_IDLE;
                        idle_out <= 1'b1;
                    end
                end
                ST_INIT: begin
                    for (int i = 0; i < 4; i++) begin
                        weight[i] <= weight_in[i];
                        credit[i] <= weight_in[i];
                    end
                    ptr <= 2'd0;
                    if (!init) begin
                        state    <= ST_IDLE;
                        idle_out <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        state    <= ST_INIT;
                        idle_out <= 1'b0;
                    end else if (fifo_empty != 4'hF) begin
                        state      <= ST_ACTIVE;
                        idle_out   <= 1'b0;
                        active_out <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (init) begin
                        state      <= ST_INIT;
                        active_out <= 1'b0;
                    end else if ((fifo_empty == 4'hF) && !inflight) begin
                        state      <= ST_IDLE;
                        active_out <= 1'b0;
                        idle_out   <= 1'b1;
                    end
                    // The pointer stays on a class until its credit runs out.
                    if (grant) begin
                        credit[sel] <= credit[sel] - WEIGHT_W'(1);
                        ptr         <= (credit[sel] == WEIGHT_W'(1)) ? sel + 2'd1 : sel;
                    end else if (reload) begin
                        for (int i = 0; i < 4; i++) begin
                            credit[i] <= weight[i];
                        end
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    // FIFO read data arrives the cycle after pop and is registered onto the egress port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight     <= 1'b0;
            inflight_idx <= 2'd0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            grant_idx    <= 2'd0;
        end else begin
            inflight <= grant;
            if (grant) begin
                inflight_idx <= sel;
            end
            valid_out <= inflight;
            if (inflight) begin
                data_out  <= fifo_data[inflight_idx];
                grant_idx <= inflight_idx;
            end
        end
    end

`ifdef QOS_GRANT_CNT_EN
    logic [7:0] grant_cnt [4];
    logic [9:0] cnt_sum;
    logic [7:0] cnt_rd;

    always_comb begin
        cnt_sum = 10'(grant_cnt[0]) + 10'(grant_cnt[1]) + 10'(grant_cnt[2]) + 10'(grant_cnt[3]);
        cnt_rd  = 8'd0;
        if (idx < 3'd4) begin
            cnt_rd = grant_cnt[idx[1:0]];
        end else if (idx == 3'd4) begin
            cnt_rd = (cnt_sum > 10'd255) ? 8'hFF : cnt_sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                grant_cnt[i] <= 8'd0;
            end
            cnt_valid <= 1'b0;
            cnt_data  <= 8'd0;
        end else begin
            if (state == ST_INIT) begin
                for (int i = 0; i < 4; i++) begin
                    grant_cnt[i] <= 8'd0;
                end
            end else if (valid_out && (grant_cnt[grant_idx] != 8'hFF)) begin
                grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 8'd1;
            end
            cnt_valid <= req;
            if (req) begin
                cnt_data <= cnt_rd;
            end
        end
    end
`else
    logic unused_cnt_inputs;

    assign unused_cnt_inputs = ^{req, idx};
    assign cnt_valid         = 1'b0;
    assign cnt_data          = 8'd0;
`endif

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Scoreboard bench for qos_wrr_scheduler: FIFO models feed the DUT, expected pops
// come from fixed WRR sequences and expected egress words are queued per pop.
module tb_qos_wrr_scheduler;

    localparam int DATA_W   = 12;
    localparam int WEIGHT_W = 4;
    localparam int BUBBLE   = 4;

    logic                clk;
    logic                reset;
    logic                init;
    logic [WEIGHT_W-1:0] weight0, weight1, weight2, weight3;
    logic [3:0]          fifo_empty;
    logic [DATA_W-1:0]   fifo_data0, fifo_data1, fifo_data2, fifo_data3;
    logic                dest_almost_full;
    logic [3:0]          pop;
    logic [DATA_W-1:0]   data_out;
    logic                valid_out;
    logic [1:0]          grant_idx;
    logic                active_out;
    logic                idle_out;
    logic                req;
    logic [2:0]          idx;
    logic                cnt_valid;
    logic [7:0]          cnt_data;

    logic [DATA_W-1:0]   mem [4][16];
    logic [DATA_W-1:0]   fdata [4];
    logic [7:0]          rd [4];
    logic [7:0]          wr [4];
    logic [7:0]          exp_rd [4];
    logic [13:0]         sb [$];
    int                  n_compared;
    int                  n_mismatched;
    int                  valid_cnt;
    int                  serial;
    int                  v0;

    int seq2 [19] = '{0, 0, 0, 1, 1, 2, 3, BUBBLE, 0, 1, 1, 2, 3, BUBBLE, 2, 3, BUBBLE, 2, 3};
    int seq3 [3]  = '{0, BUBBLE, 0};
    int seq4 [8]  = '{3, BUBBLE, 0, 1, 2, 3, BUBBLE, 0};

    qos_wrr_scheduler #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .DEFAULT_WEIGHT(1)) dut (
        .clk(clk), .reset(reset), .init(init),
        .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
        .fifo_empty(fifo_empty),
        .fifo_data0(fifo_data0), .fifo_data1(fifo_data1),
        .fifo_data2(fifo_data2), .fifo_data3(fifo_data3),
        .dest_almost_full(dest_almost_full),
        .pop(pop), .data_out(data_out), .valid_out(valid_out), .grant_idx(grant_idx),
        .active_out(active_out), .idle_out(idle_out),
        .req(req), .idx(idx), .cnt_valid(cnt_valid), .cnt_data(cnt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_data0 = fdata[0];
    assign fifo_data1 = fdata[1];
    assign fifo_data2 = fdata[2];
    assign fifo_data3 = fdata[3];

    always_comb begin
        fifo_empty = 4'h0;
        for (int i = 0; i < 4; i++) fifo_empty[i] = (rd[i] == wr[i]);
    end

    // Class FIFO models: read data appears the cycle after a pop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rd[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i] && (rd[i] != wr[i])) begin
                    fdata[i] <= mem[i][rd[i][3:0]];
                    rd[i]    <= rd[i] + 8'd1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic i, input int w0, input int w1, input int w2, input int w3);
        init    = i;
        weight0 = WEIGHT_W'(w0);
        weight1 = WEIGHT_W'(w1);
        weight2 = WEIGHT_W'(w2);
        weight3 = WEIGHT_W'(w3);
    endtask

    task automatic load(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            mem[c][wr[c][3:0]] = DATA_W'((c << 8) | (serial & 8'hFF));
            serial++;
            wr[c] = wr[c] + 8'd1;
        end
    endtask

    task automatic expect_pop(input int e);
        logic [3:0] exp_pop;
        exp_pop = (e < 4) ? 4'(1 << e) : 4'h0;
        checkOutput("pop", 32'(pop), 32'(exp_pop));
        if (e < 4) begin
            sb.push_back({2'(e), mem[e][exp_rd[e][3:0]]});
            exp_rd[e] = exp_rd[e] + 8'd1;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (idle_out) break;
            @(negedge clk); #1;
        end
        checkOutput(tag, 32'(idle_out), 32'd1);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic read_cnt(input int i, input int expv);
        req = 1'b1;
        idx = 3'(i);
        @(negedge clk); #1;
        checkOutput("cnt_valid", 32'(cnt_valid), 32'd1);
        checkOutput("cnt_data", 32'(cnt_data), 32'(expv));
        req = 1'b0;
    endtask

    // Egress scoreboard: every valid word must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            valid_cnt++;
            if (sb.size() == 0) checkOutput("valid_with_empty_scoreboard", 32'(valid_out), 32'd0);
            else checkOutput("egress_word", 32'({grant_idx, data_out}), 32'(sb.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared = 0; n_mismatched = 0; valid_cnt = 0; serial = 0;
        reset = 1'b1; dest_almost_full = 1'b0; req = 1'b0; idx = 3'd0;
        applyStimulus(1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin wr[i] = 8'd0; exp_rd[i] = 8'd0; end
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_pop", 32'(pop), 32'd0);
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_data", 32'(data_out), 32'd0);
        checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
        checkOutput("rst_active", 32'(active_out), 32'd0);
        checkOutput("rst_idle", 32'(idle_out), 32'd0);

        $display("[TB] init with weights 3/2/1/1");
        reset = 1'b0;
        applyStimulus(1'b1, 3, 2, 1, 1);
        @(negedge clk); #1;
        checkOutput("init_idle_low", 32'(idle_out), 32'd0);
        checkOutput("init_pop", 32'(pop), 32'd0);
        init = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_flag", 32'(idle_out), 32'd1);
        checkOutput("idle_active_low", 32'(active_out), 32'd0);

        $display("[TB] drain four words per class");
        for (int c = 0; c < 4; c++) load(c, 4);
        #1;
        checkOutput("idle_no_pop", 32'(pop), 32'd0);
        foreach (seq2[i]) begin @(negedge clk); #1; expect_pop(seq2[i]); end
        wait_idle("idle_after_drain");
`ifdef QOS_GRANT_CNT_EN
        for (int i = 0; i < 4; i++) read_cnt(i, 4);
        read_cnt(4, 16);
`else
        req = 1'b1; idx = 3'd0;
        @(negedge clk); #1;
        checkOutput("cnt_valid_off", 32'(cnt_valid), 32'd0);
        checkOutput("cnt_data_off", 32'(cnt_data), 32'd0);
        req = 1'b0;
`endif

        $display("[TB] weight 0 starves class 0");
        applyStimulus(1'b1, 0, 1, 1, 1);
        @(negedge clk); #1;
        init = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_after_reinit", 32'(idle_out), 32'd1);
`ifdef QOS_GRANT_CNT_EN
        for (int i = 0; i < 8; i++) read_cnt(i, 0);
`endif
        load(0, 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            checkOutput("starved_pop", 32'(pop), 32'd0);
            checkOutput("starved_active", 32'(active_out), 32'd1);
        end
        applyStimulus(1'b1, 1, 1, 1, 1);
        #1;
        checkOutput("init_gates_pop", 32'(pop), 32'd0);
        @(negedge clk); #1;
        init = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_before_resume", 32'(idle_out), 32'd1);
        foreach (seq3[i]) begin @(negedge clk); #1; expect_pop(seq3[i]); end
        wait_idle("idle_after_p0");

        $display("[TB] backpressure after a class 1 pop");
        for (int c = 0; c < 4; c++) load(c, 2);
        @(negedge clk); #1;
        expect_pop(1);
        @(negedge clk); #1;
        dest_almost_full = 1'b1;
        v0 = valid_cnt;
        #1;
        checkOutput("stall_pop", 32'(pop), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checkOutput("stall_pop", 32'(pop), 32'd0);
        end
        checkOutput("words_during_stall", 32'(valid_cnt - v0), 32'd1);
        dest_almost_full = 1'b0;
        #1;
        expect_pop(2);
        foreach (seq4[i]) begin @(negedge clk); #1; expect_pop(seq4[i]); end
        wait_idle("idle_after_stall");

        $display("[TB] init while a word is in flight");
        load(1, 3);
        @(negedge clk); #1;
        expect_pop(1);
        @(negedge clk); #1;
        applyStimulus(1'b1, 2, 2, 2, 2);
        #1;
        expect_pop(BUBBLE);
        @(negedge clk); #1;
        checkOutput("inflight_delivered", 32'(valid_out), 32'd1);
        checkOutput("init_pop_blocked", 32'(pop), 32'd0);
        init = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_after_init", 32'(idle_out), 32'd1);
        @(negedge clk); #1; expect_pop(1);
        @(negedge clk); #1; expect_pop(1);
        wait_idle("idle_after_new_weights");

        $display("[TB] reset with a word in flight");
        load(2, 2);
        @(negedge clk); #1;
        expect_pop(2);
        @(negedge clk); #1;
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin wr[i] = 8'd0; exp_rd[i] = 8'd0; end
        #1;
        checkOutput("midrst_valid", 32'(valid_out), 32'd0);
        checkOutput("midrst_data", 32'(data_out), 32'd0);
        checkOutput("midrst_pop", 32'(pop), 32'd0);
        checkOutput("midrst_active", 32'(active_out), 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checkOutput("no_valid_after_reset", 32'(valid_out), 32'd0);
        end
        checkOutput("idle_after_reset", 32'(idle_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
